// File: rtl/remote_bus_arbiter_pkg.sv
// Shared definitions for the remote bus arbiter: word width, strobe encoding
// and the offset helper for flattened per-core buses.
package remote_bus_arbiter_pkg;

  localparam int WORD_W = 16;

  // Encoding of {wren, rden} as seen on one requester port.
  typedef enum logic [1:0] {
    STROBE_IDLE  = 2'b00,
    STROBE_READ  = 2'b01,
    STROBE_WRITE = 2'b10,
    STROBE_BOTH  = 2'b11
  } strobe_e;

  // Low bit of core idx's word in a flattened {core[N-1], ..., core[0]} bus.
  function automatic int slice_lo(input int idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after prio_ptr,
// wrapping modulo NUM_CORES.
module rr_priority_picker #(
  parameter  int NUM_CORES = 4,
  localparam int GRANT_W   = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [GRANT_W-1:0]   prio_ptr,
  output logic [GRANT_W-1:0]   grant,
  output logic                 any_req
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant   = '0;
    any_req = |req;
    // Scan from farthest to nearest so the nearest requester is assigned last.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      int idx;
      idx = int'(prio_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (req[idx]) grant = GRANT_W'(idx);
    end
  end

endmodule

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter sharing one remote memory/device bus among NUM_CORES
// cores; the grant is held across downstream wait states.
module remote_bus_arbiter
  import remote_bus_arbiter_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  localparam int GRANT_W   = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WORD_W*NUM_CORES-1:0] core_addr,
  input  logic [NUM_CORES-1:0]        core_wren,
  input  logic [NUM_CORES-1:0]        core_rden,
  input  logic [WORD_W*NUM_CORES-1:0] core_write_val,
  output logic [NUM_CORES-1:0]        core_ready,
  output logic [WORD_W-1:0]           core_read_val,
  output logic [WORD_W-1:0]           mem_addr,
  output logic                        mem_wren,
  output logic                        mem_rden,
  output logic [WORD_W-1:0]           mem_write_val,
  input  logic                        mem_ready,
  input  logic [WORD_W-1:0]           mem_read_val
);

  logic [NUM_CORES-1:0] req;
  logic [GRANT_W-1:0]   prio_ptr;
  logic [GRANT_W-1:0]   lock_idx;
  logic [GRANT_W-1:0]   pick_grant;
  logic [GRANT_W-1:0]   grant;
  logic [GRANT_W-1:0]   sel;
  logic                 locked;
  logic                 any_req;
  logic                 gnt_valid;
  strobe_e              strobe;

  assign req = core_wren | core_rden;

  rr_priority_picker #(.NUM_CORES(NUM_CORES)) u_picker (
    .req      (req),
    .prio_ptr (prio_ptr),
    .grant    (pick_grant),
    .any_req  (any_req)
  );

  // A stalled access keeps its grant until the downstream completes it.
  assign grant     = locked ? lock_idx : pick_grant;
  assign gnt_valid = locked | any_req;

  // When idle, steer the mux to core 0 so the address/data never float to X.
  assign sel           = gnt_valid ? grant : '0;
  assign strobe        = strobe_e'({core_wren[sel], core_rden[sel]});
  assign mem_addr      = core_addr[slice_lo(int'(sel)) +: WORD_W];
  assign mem_write_val = core_write_val[slice_lo(int'(sel)) +: WORD_W];
  assign mem_wren      = gnt_valid & ~reset & strobe[1];
  assign mem_rden      = gnt_valid & ~reset & strobe[0];

  always_comb begin
    core_ready = '0;
    if (gnt_valid && mem_ready && !reset) core_ready[grant] = 1'b1;
  end

  // Read data lands one cycle after ready; only the core readied last cycle samples it.
  assign core_read_val = mem_read_val;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      prio_ptr <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (gnt_valid) begin
      if (mem_ready) begin
        prio_ptr <= (grant == GRANT_W'(NUM_CORES - 1)) ? '0 : grant + GRANT_W'(1);
        locked   <= 1'b0;
      end else begin
        locked   <= 1'b1;
        lock_idx <= grant;
      end
    end
  end

endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Directed bench for remote_bus_arbiter with four cores: reset, single access,
// rotation, wait-state lock, priority order, reset mid-stall and idle.
module tb_remote_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] core_addr;
  logic [3:0]  core_wren;
  logic [3:0]  core_rden;
  logic [63:0] core_write_val;
  logic [3:0]  core_ready;
  logic [15:0] core_read_val;
  logic [15:0] mem_addr;
  logic        mem_wren;
  logic        mem_rden;
  logic [15:0] mem_write_val;
  logic        mem_ready;
  logic [15:0] mem_read_val;

  int vectors     = 0;
  int miscompares = 0;

  logic [21:0] want;

  remote_bus_arbiter #(.NUM_CORES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_addr      (core_addr),
    .core_wren      (core_wren),
    .core_rden      (core_rden),
    .core_write_val (core_write_val),
    .core_ready     (core_ready),
    .core_read_val  (core_read_val),
    .mem_addr       (mem_addr),
    .mem_wren       (mem_wren),
    .mem_rden       (mem_rden),
    .mem_write_val  (mem_write_val),
    .mem_ready      (mem_ready),
    .mem_read_val   (mem_read_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Protocol monitors: no core drives both strobes, and no requester drops
  // its request while the bus is stalled.
  logic [3:0] req_q;
  logic       stall_q = 1'b0;
  always @(posedge clk) begin
    if (!reset) begin
      assert ((core_wren & core_rden) == 4'b0)
        else $error("core drives wren and rden together: %b", core_wren & core_rden);
      if (stall_q)
        assert ((req_q & ~(core_wren | core_rden)) == 4'b0)
          else $error("request dropped during stall: %b -> %b", req_q, core_wren | core_rden);
    end
    stall_q <= (mem_wren | mem_rden) & ~mem_ready & ~reset;
    req_q   <= core_wren | core_rden;
  end

  // {core_ready, mem_wren, mem_rden, mem_addr}
  function automatic logic [21:0] bus_view();
    return {core_ready, mem_wren, mem_rden, mem_addr};
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data);
    core_wren[i]            = wr;
    core_rden[i]            = ~wr;
    core_addr[i*16 +: 16]      = addr;
    core_write_val[i*16 +: 16] = data;
  endtask

  task automatic drop_req(input int i);
    core_wren[i] = 1'b0;
    core_rden[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; core_rden = 4'b0001; mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (bus_view() !== 22'h0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %h want %h", c, bus_view(), 22'h0);
      end
      @(negedge clk);
    end
    reset = 1'b0; core_rden = 4'b0000;
    #1;
    vectors++;
    if (bus_view() !== 22'h0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", bus_view(), 22'h0);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_req(2, 1'b0, 16'h8000, 16'h0); mem_ready = 1'b1;
    #1;
    want = {4'b0100, 1'b0, 1'b1, 16'h8000};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL single_read: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    drop_req(2); mem_read_val = 16'hBEEF;
    #1;
    vectors++;
    if (core_read_val !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL single_read_data: got %h want %h", core_read_val, 16'hBEEF);
    end
    want = {4'b0000, 1'b0, 1'b0, 16'h0000};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL single_read_after: got %h want %h", bus_view(), want);
    end
    mem_read_val = 16'h0;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'h1000 + 16'(i), 16'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      want = {4'(1 << (k % 4)), 1'b0, 1'b1, 16'h1000 + 16'(k % 4)};
      vectors++;
      if (bus_view() !== want) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: got %h want %h", k, bus_view(), want);
      end
      @(negedge clk);
    end
    core_wren = '0; core_rden = '0;
  endtask

  task automatic test_stall_write();
    @(negedge clk);
    set_req(0, 1'b0, 16'h0100, 16'h0); mem_ready = 1'b1;
    #1;
    want = {4'b0001, 1'b0, 1'b1, 16'h0100};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL stall_pre: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    set_req(1, 1'b1, 16'h9000, 16'h1234); mem_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) mem_ready = 1'b1;
      #1;
      want = {(s == 3) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, 16'h9000};
      vectors++;
      if (bus_view() !== want || mem_write_val !== 16'h1234) begin
        miscompares++;
        $display("FAIL stall_write[%0d]: got %h/%h want %h/%h", s, bus_view(),
                 mem_write_val, want, 16'h1234);
      end
      @(negedge clk);
    end
    drop_req(1);
    #1;
    want = {4'b0001, 1'b0, 1'b1, 16'h0100};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL stall_next: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    core_wren = '0; core_rden = '0;
  endtask

  task automatic test_prio_order();
    @(negedge clk);
    set_req(0, 1'b1, 16'hA000, 16'h0A0A);
    set_req(3, 1'b1, 16'hA300, 16'h3A3A);
    mem_ready = 1'b1;
    #1;
    want = {4'b1000, 1'b1, 1'b0, 16'hA300};
    vectors++;
    if (bus_view() !== want || mem_write_val !== 16'h3A3A) begin
      miscompares++;
      $display("FAIL prio_first: got %h/%h want %h/%h", bus_view(), mem_write_val, want, 16'h3A3A);
    end
    @(negedge clk);
    #1;
    want = {4'b0001, 1'b1, 1'b0, 16'hA000};
    vectors++;
    if (bus_view() !== want || mem_write_val !== 16'h0A0A) begin
      miscompares++;
      $display("FAIL prio_second: got %h/%h want %h/%h", bus_view(), mem_write_val, want, 16'h0A0A);
    end
    @(negedge clk);
    drop_req(0);
    #1;
    want = {4'b1000, 1'b1, 1'b0, 16'hA300};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL prio_third: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    core_wren = '0; core_rden = '0;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    set_req(1, 1'b0, 16'hB100, 16'h0); mem_ready = 1'b1;
    #1;
    want = {4'b0010, 1'b0, 1'b1, 16'hB100};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL rst_stall_pre: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    drop_req(1); set_req(2, 1'b0, 16'hB200, 16'h0); mem_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      want = {4'b0000, 1'b0, 1'b1, 16'hB200};
      vectors++;
      if (bus_view() !== want) begin
        miscompares++;
        $display("FAIL rst_stall_hold[%0d]: got %h want %h", s, bus_view(), want);
      end
      @(negedge clk);
    end
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    vectors++;
    if (bus_view() >> 16 !== 22'h0) begin
      miscompares++;
      $display("FAIL rst_stall_reset: got ready/strobes %h want %h", bus_view() >> 16, 22'h0);
    end
    @(negedge clk);
    reset = 1'b0; set_req(0, 1'b0, 16'hB000, 16'h0);
    #1;
    want = {4'b0001, 1'b0, 1'b1, 16'hB000};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL rst_stall_regrant: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    drop_req(0);
    #1;
    want = {4'b0100, 1'b0, 1'b1, 16'hB200};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL rst_stall_core2: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    core_wren = '0; core_rden = '0;
  endtask

  task automatic test_idle();
    core_addr[15:0] = 16'h00AA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      core_wren = '0; core_rden = '0; mem_ready = i[0];
      #1;
      want = {4'b0000, 1'b0, 1'b0, 16'h00AA};
      vectors++;
      if (bus_view() !== want) begin
        miscompares++;
        $display("FAIL idle[%0d]: got %h want %h", i, bus_view(), want);
      end
    end
    // Pointer still at 3 after the idle stretch: core 3 wins over core 0.
    @(negedge clk);
    set_req(0, 1'b0, 16'hC000, 16'h0);
    set_req(3, 1'b0, 16'hC300, 16'h0);
    mem_ready = 1'b1;
    #1;
    want = {4'b1000, 1'b0, 1'b1, 16'hC300};
    vectors++;
    if (bus_view() !== want) begin
      miscompares++;
      $display("FAIL idle_ptr_kept: got %h want %h", bus_view(), want);
    end
    @(negedge clk);
    core_wren = '0; core_rden = '0;
  endtask

  initial begin
    reset = 1'b1; core_addr = '0; core_write_val = '0;
    core_wren = '0; core_rden = '0; mem_ready = 1'b0; mem_read_val = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall_write();
    test_prio_order();
    test_reset_mid_stall();
    test_idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/remote_bus_arbiter.md
Name: remote_bus_arbiter

Overview:
- Shares one remote (non-local) memory/device bus among NUM_CORES cores.
- Each core's remote_* port connects to one requester port. The downstream port drives the shared global memory or the I/O fabric.
- Round-robin, one transaction per granted cycle. The grant is held while the downstream inserts wait states.
- Read data reaches the requester in the cycle after its ready pulse, which matches the core's one-cycle-delayed read path.

Parameters:
- NUM_CORES, 4, number of requesting cores; 2..16.
- GRANT_W, $clog2(NUM_CORES), width of the grant index and priority pointer (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- core_addr  in  16*NUM_CORES  per-core remote_addr; slice i = [16*i+15:16*i].
- core_wren  in  NUM_CORES  per-core remote write request.
- core_rden  in  NUM_CORES  per-core remote read request.
- core_write_val  in  16*NUM_CORES  per-core write data.
- core_ready  out  NUM_CORES  per-core remote_ready; the transaction completes this cycle.
- core_read_val  out  16  read data, broadcast to all cores' remote_read_val.
- mem_addr  out  16  downstream address.
- mem_wren  out  1  downstream write strobe.
- mem_rden  out  1  downstream read strobe.
- mem_write_val  out  16  downstream write data.
- mem_ready  in  1  downstream accepts/completes the current access this cycle.
- mem_read_val  in  16  downstream read data; valid the cycle after mem_ready with mem_rden.

Behaviour:
- req[i] = core_wren[i] | core_rden[i]. A core holds addr, data and strobes stable until it sees core_ready[i].
- State registers:
  - prio_ptr (GRANT_W): reset value 0.
  - locked (1): reset value 0.
  - lock_idx (GRANT_W): reset value 0.
- Grant selection (combinational):
  - If locked, grant = lock_idx.
  - Otherwise grant = the first i with req[i] set, scanning prio_ptr, prio_ptr+1, … mod NUM_CORES.
  - gnt_valid = locked | (|req).
- Downstream outputs:
  - mem_addr, mem_write_val, mem_wren and mem_rden are muxed from the granted core.
  - mem_wren and mem_rden are forced 0 when !gnt_valid or reset.
  - mem_addr and mem_write_val are don't-care when idle but must not be X; drive slice 0.
- core_ready[i] = gnt_valid & (grant==i) & mem_ready & !reset. All other bits are 0. At most one bit is set per cycle.
- core_read_val = mem_read_val, passed straight through. Only the core readied in the previous cycle samples it; other cores ignore it.
- Sequential update on posedge clk:
  - reset: prio_ptr<=0, locked<=0, lock_idx<=0.
  - gnt_valid & mem_ready: prio_ptr<=(grant==NUM_CORES-1)?0:grant+1; locked<=0.
  - gnt_valid & !mem_ready: locked<=1; lock_idx<=grant; prio_ptr unchanged.
  - !gnt_valid: no change.
- Latency: zero added cycles. A lone requester with mem_ready=1 completes in the same cycle it requests.
- Back-to-back: the same core may be granted on consecutive cycles only if no other core requests.
- Fairness: a requester waits at most NUM_CORES-1 completed transactions.
- Simultaneous wren&rden from one core is illegal; it is forwarded unchanged. A bench assertion flags it.
- Reset mid-stall clears the lock. The next grant is recomputed from prio_ptr=0.
- A locked core that drops its request is a protocol violation. The arbiter keeps the lock until mem_ready; the bench asserts the request holds.

Decomposition:
- Shared header/package: word width (16), strobe encoding, and the slice macro for flattened per-core buses.
- Sub-module rr_priority_picker(NUM_CORES): combinational, takes req and prio_ptr and returns grant index and any_req. Reusable for a later I/O arbiter.

Test Plan:
- Single core 2 reads addr 0x8000, mem_ready=1 → mem_rden=1 with mem_addr=0x8000 and core_ready=4'b0100 the same cycle. mem_read_val=0xBEEF next cycle appears on core_read_val.
- All 4 cores request continuously, mem_ready=1 → grant order 0,1,2,3,0,…; core_ready one-hot, rotating each cycle.
- Core 1 writes 0x1234 to 0x9000 with mem_ready low for 3 cycles while core 0 also requests:
  - grant stays on 1 with mem_addr stable.
  - core_ready[1] pulses on the 4th cycle, then core 0 is granted.
- Cores 0 and 3 request, prio_ptr=1 → core 3 granted first, then core 0.
- Reset asserted during a locked stall on core 2 → the next cycle has mem strobes 0 and core_ready 0. After reset with cores 0 and 2 requesting, core 0 is granted.
- No requests for 10 cycles → mem_wren=mem_rden=0, core_ready=0, prio_ptr unchanged.
